// File: rtl/rom4001_responder_if.sv
// Bus bundle between the 4004 core and a 4001-style ROM/I-O responder.
interface rom4001_responder_if;
  logic       phaseEn;
  logic       sync;
  logic       cmRom;
  logic [3:0] dataIn;
  logic [3:0] dataOut;
  logic       dataOe;
  logic [3:0] ioIn;
  logic [3:0] ioOut;
  logic       locked;

  // Core side drives the bus phase timing and nibbles; reads back responder drive.
  modport master (
    output phaseEn, sync, cmRom, dataIn, ioIn,
    input  dataOut, dataOe, ioOut, locked
  );

  // Responder side.
  modport slave (
    input  phaseEn, sync, cmRom, dataIn, ioIn,
    output dataOut, dataOe, ioOut, locked
  );
endinterface

// File: rtl/rom4001_responder.sv
// 4001-style ROM slice with 4-bit I/O port on the 4004 multiplexed bus.
// The ROM image is a 256 x 8 packed parameter; byte n sits at bits [8n+7:8n], byte = {OPR,OPA}.
module rom4001_responder #(
  parameter logic [3:0]    CHIP_ID   = 4'h0,
  parameter logic [2047:0] ROM_IMAGE = '0
) (
  input logic                clk,
  input logic                rst,
  rom4001_responder_if.slave bus
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0, PH_A2 = 3'd1, PH_A3 = 3'd2, PH_M1 = 3'd3,
    PH_M2 = 3'd4, PH_X1 = 3'd5, PH_X2 = 3'd6, PH_X3 = 3'd7
  } phase_t;

  typedef enum logic [1:0] {IO_NONE = 2'd0, IO_WRR = 2'd1, IO_RDR = 2'd2} io_op_t;

  localparam logic [3:0] OPR_IO  = 4'hE;
  localparam logic [3:0] OPA_WRR = 4'h2;
  localparam logic [3:0] OPA_RDR = 4'hA;

  phase_t     phase_q, phase_d;
  io_op_t     io_op_q, io_op_d;
  logic       locked_q, locked_d;
  logic       hit_q, hit_d;
  logic       src_sel_q, src_sel_d;
  logic       data_oe_q, data_oe_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] rom_data_q, rom_data_d;
  logic [3:0] opr_q, opr_d;
  logic [3:0] opa_q, opa_d;
  logic [3:0] data_out_q, data_out_d;
  logic [3:0] io_out_q, io_out_d;
  logic [7:0] rom_byte;
  logic [3:0] opa_eff;

  // Asynchronous ROM lookup at the fully latched address.
  assign rom_byte = ROM_IMAGE[{addr_q, 3'b000} +: 8];

  // State register; rst returns everything to idle, unframed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= PH_X3;
      io_op_q    <= IO_NONE;
      locked_q   <= 1'b0;
      hit_q      <= 1'b0;
      src_sel_q  <= 1'b0;
      data_oe_q  <= 1'b0;
      addr_q     <= '0;
      rom_data_q <= '0;
      opr_q      <= '0;
      opa_q      <= '0;
      data_out_q <= '0;
      io_out_q   <= '0;
    end else begin
      phase_q    <= phase_d;
      io_op_q    <= io_op_d;
      locked_q   <= locked_d;
      hit_q      <= hit_d;
      src_sel_q  <= src_sel_d;
      data_oe_q  <= data_oe_d;
      addr_q     <= addr_d;
      rom_data_q <= rom_data_d;
      opr_q      <= opr_d;
      opa_q      <= opa_d;
      data_out_q <= data_out_d;
      io_out_q   <= io_out_d;
    end
  end

  // Phase sequencing plus the latch/drive action tied to the phase that is ending.
  always_comb begin
    phase_d    = phase_q;
    io_op_d    = io_op_q;
    locked_d   = locked_q;
    hit_d      = hit_q;
    src_sel_d  = src_sel_q;
    data_oe_d  = data_oe_q;
    addr_d     = addr_q;
    rom_data_d = rom_data_q;
    opr_d      = opr_q;
    opa_d      = opa_q;
    data_out_d = data_out_q;
    io_out_d   = io_out_q;
    opa_eff    = hit_q ? opa_q : bus.dataIn;

    if (bus.phaseEn) begin
      // Drive lasts exactly one phase unless re-asserted below.
      data_oe_d  = 1'b0;
      data_out_d = '0;
      if (bus.sync) begin
        // Phase ending is X3 by definition; any partial cycle is abandoned.
        phase_d  = PH_A1;
        locked_d = 1'b1;
      end else begin
        phase_d = phase_t'(3'(phase_q + 3'd1));
        if (locked_q) begin
          case (phase_q)
            PH_A1: addr_d[3:0] = bus.dataIn;
            PH_A2: addr_d[7:4] = bus.dataIn;
            PH_A3: begin
              hit_d      = (bus.dataIn == CHIP_ID);
              rom_data_d = rom_byte;
              if (bus.dataIn == CHIP_ID) begin
                data_out_d = rom_byte[7:4];
                data_oe_d  = 1'b1;
                opr_d      = rom_byte[7:4];
              end
            end
            PH_M1: begin
              if (hit_q) begin
                data_out_d = rom_data_q[3:0];
                data_oe_d  = 1'b1;
                opa_d      = rom_data_q[3:0];
              end else begin
                opr_d = bus.dataIn;
              end
            end
            PH_M2: begin
              if (!hit_q) opa_d = bus.dataIn;
              io_op_d = IO_NONE;
              if (bus.cmRom && opr_q == OPR_IO) begin
                if (opa_eff == OPA_WRR)      io_op_d = IO_WRR;
                else if (opa_eff == OPA_RDR) io_op_d = IO_RDR;
              end
            end
            PH_X1: begin
              if (io_op_q == IO_RDR && src_sel_q) begin
                data_out_d = bus.ioIn;
                data_oe_d  = 1'b1;
              end
            end
            PH_X2: begin
              if (io_op_q == IO_WRR && src_sel_q) io_out_d = bus.dataIn;
              if (bus.cmRom && io_op_q == IO_NONE) src_sel_d = (bus.dataIn == CHIP_ID);
            end
            PH_X3: ;
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.dataOut = data_out_q;
  assign bus.dataOe  = data_oe_q;
  assign bus.ioOut   = io_out_q;
  assign bus.locked  = locked_q;

endmodule
